// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice processes a nibble per clock, LSB first.
// Optional carry-in port c_in is enabled by defining SERIAL_ADD_CIN_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             c_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [3:0]         slice_sum;
  logic [4:0]         slice_c;
  logic               cin_sel;

`ifdef SERIAL_ADD_CIN_EN
  assign cin_sel = c_in;
`else
  assign cin_sel = 1'b0;
`endif

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*4 +: 4];
        b_nib = b_q[i*4 +: 4];
      end
    end
  end

  assign slice_c[0] = carry_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      full_adder u_fa (
        .a  (a_nib[gi]),
        .b  (b_nib[gi]),
        .ci (slice_c[gi]),
        .s  (slice_sum[gi]),
        .co (slice_c[gi+1])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin_sel;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*4 +: 4] = slice_sum;
          end
        end
        carry_d = slice_c[4];
        if (idx_q == LAST_IDX) begin
          c_out_d = slice_c[4];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        // Retire only; a coincident in_valid is picked up from IDLE next cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16); carry-in scenario runs when SERIAL_ADD_CIN_EN is defined.

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] sum;
  logic        c_out;
  logic        busy;

`ifdef SERIAL_ADD_CIN_EN
  logic        c_in = 1'b0;
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;
  logic [16:0] sb[$];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_CIN_EN
    .c_in      (c_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Present one operand pair for a single accept edge and record the expected result.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int w = 0;
    logic [16:0] e;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    a = x;
    b = y;
`ifdef SERIAL_ADD_CIN_EN
    c_in = ci;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = {1'b0, x} + {1'b0, y} + {16'd0, ci & CIN_EN};
    sb.push_back(e);
    $display("send a=%h b=%h ci=%0d expect sum=%h c_out=%0d", x, y, ci & CIN_EN, e[15:0], e[16]);
  endtask

  // Wait (bounded) for out_valid; n counts edges waited.
  task automatic wait_out(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, c_out, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b c_out=%b sum=%h required 1 0 0 0 0000",
               in_ready, out_valid, busy, c_out, sum);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: busy=%b in_ready=%b required 0 1", busy, in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    int n; bit ok; logic [16:0] e;
    out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0);
    wait_out(n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n != 4) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles (ok=%0d) required 4", n, ok);
    end
    checks++;
    if (sum !== e[15:0] || c_out !== e[16] || sum !== 16'h5555) begin
      fails++;
      $display("FAIL basic_sum: sum=%h c_out=%b required %h %b", sum, c_out, e[15:0], e[16]);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_done_flags: in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_retire: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    $display("test_basic sum=%h c_out=%b latency=%0d", sum, c_out, n);
  endtask

  task automatic test_carry_ripple;
    int n; bit ok; logic [16:0] e;
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_out(n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || sum !== e[15:0] || c_out !== e[16]) begin
      fails++;
      $display("FAIL carry_ripple: sum=%h c_out=%b required %h %b", sum, c_out, e[15:0], e[16]);
    end
    @(posedge clk); #1;
    $display("test_carry_ripple sum=%h c_out=%b", sum, c_out);
  endtask

  task automatic test_backpressure;
    int n; bit ok; logic [16:0] e;
    out_ready = 1'b0;
    send(16'h00F0, 16'h0F10, 1'b0);
    wait_out(n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || e[15:0] !== 16'h1000) begin
      fails++;
      $display("FAIL bp_valid: ok=%0d model=%h required out_valid and 1000", ok, e[15:0]);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        a = 16'h7777;
        b = 16'h1111;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[15:0] || c_out !== e[16]) begin
        fails++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h c_out=%b required 1 0 %h %b",
                 i, out_valid, in_ready, sum, c_out, e[15:0], e[16]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_retire_only: out_valid=%b busy=%b in_ready=%b required 0 0 1", out_valid, busy, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    $display("test_backpressure sum=%h", e[15:0]);
  endtask

  task automatic test_ignore_busy;
    int n; bit ok; logic [16:0] e;
    send(16'h1234, 16'h4321, 1'b0);
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n + 1 != 4 || sum !== e[15:0] || c_out !== e[16]) begin
      fails++;
      $display("FAIL ignore_busy: latency=%0d sum=%h c_out=%b required 4 %h %b", n + 1, sum, c_out, e[15:0], e[16]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL ignore_no_accept%0d: busy=%b out_valid=%b required 0 0", i, busy, out_valid);
      end
    end
    $display("test_ignore_busy sum=%h", e[15:0]);
  endtask

  task automatic test_reset_mid_run;
    int n; bit ok; logic [16:0] e;
    int spurious = 0;
    send(16'h8888, 16'h8888, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    checks++;
    if ({out_valid, busy, c_out, sum, in_ready} !== {1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
      fails++;
      $display("FAIL midrun_reset: out_valid=%b busy=%b c_out=%b sum=%h in_ready=%b required 0 0 0 0000 1",
               out_valid, busy, c_out, sum, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      fails++;
      $display("FAIL midrun_spurious: %0d bad cycles required 0", spurious);
    end
    send(16'h0001, 16'h0001, 1'b0);
    wait_out(n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n != 4 || sum !== e[15:0] || sum !== 16'h0002 || c_out !== e[16]) begin
      fails++;
      $display("FAIL midrun_fresh: latency=%0d sum=%h c_out=%b required 4 %h %b", n, sum, c_out, e[15:0], e[16]);
    end
    @(posedge clk); #1;
    $display("test_reset_mid_run fresh sum=%h", e[15:0]);
  endtask

  task automatic test_random;
    int n; bit ok; logic [16:0] e;
    logic [15:0] x, y;
    for (int k = 0; k < 10; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      send(x, y, 1'($urandom_range(0, 1)));
      wait_out(n, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || n != 4 || sum !== e[15:0] || c_out !== e[16]) begin
        fails++;
        $display("FAIL random%0d: latency=%0d sum=%h c_out=%b required 4 %h %b", k, n, sum, c_out, e[15:0], e[16]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL random_retire%0d: out_valid=%b required 0", k, out_valid);
      end
    end
    $display("test_random done");
  endtask

`ifdef SERIAL_ADD_CIN_EN
  task automatic test_cin;
    int n; bit ok; logic [16:0] e;
    for (int k = 0; k < 2; k++) begin
      send(16'hFFFF, 16'h0000, (k == 0) ? 1'b1 : 1'b0);
      wait_out(n, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || sum !== e[15:0] || c_out !== e[16]) begin
        fails++;
        $display("FAIL cin%0d: sum=%h c_out=%b required %h %b", k, sum, c_out, e[15:0], e[16]);
      end
      @(posedge clk); #1;
      $display("test_cin c_in=%0d sum=%h c_out=%b", 1 - k, e[15:0], e[16]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid_run();
    test_random();
`ifdef SERIAL_ADD_CIN_EN
    test_cin();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
